// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types : shared enums and helpers for the LC-3b multicycle control path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lc3b_types;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ALIGN   = 2'b01,
    ERR_TIMEOUT = 2'b10
  } mem_err_t;

  typedef enum logic [1:0] {
    MS_IDLE   = 2'd0,
    MS_IND    = 2'd1,
    MS_ACCESS = 2'd2,
    MS_FINISH = 2'd3
  } mem_seq_state_t;

  function automatic int lane_count(input int width);
    return width / 8;
  endfunction

  function automatic int lane_bits(input int width);
    return (width / 8 > 1) ? $clog2(width / 8) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_sel.sv
// ---------------------------------------------------------------------------
// mem_lane_sel : byte-lane read select / zero-extend and write replication
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_lane_sel
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [lane_bits(WIDTH)-1:0]  lane,
  input  logic                         byte_mode,
  input  logic                         byte_wr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [WIDTH-1:0]             rdata,
  output logic [WIDTH-1:0]             wdata_out,
  output logic [lane_count(WIDTH)-1:0] byte_en,
  output logic [WIDTH-1:0]             rdata_byte
);

  localparam int LANES = lane_count(WIDTH);

  logic [WIDTH-1:0] wdata_rep;
  logic [7:0]       lane_bytes [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign wdata_rep[i*8 +: 8] = wdata[7:0];
    assign lane_bytes[i]       = rdata[i*8 +: 8];
  end

  assign wdata_out  = byte_mode ? wdata_rep : wdata;
  assign byte_en    = byte_wr ? (LANES'(1) << lane) : '1;
  assign rdata_byte = {{(WIDTH-8){1'b0}}, lane_bytes[lane]};

endmodule

`default_nettype wire

// File: rtl/mem_access_seq.sv
// ---------------------------------------------------------------------------
// mem_access_seq : indirect/byte/word memory transaction engine with timeout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_seq
  import lc3b_types::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_LEVELS = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic                             req_byte,
  input  logic [$clog2(MAX_LEVELS+1)-1:0]  req_levels,
  input  logic [WIDTH-1:0]                 req_addr,
  input  logic [WIDTH-1:0]                 req_wdata,
  output logic                             done,
  output logic [1:0]                       err,
  output logic [WIDTH-1:0]                 rdata,
  output logic [WIDTH-1:0]                 mem_address,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [lane_count(WIDTH)-1:0]     mem_byte_enable,
  output logic [WIDTH-1:0]                 mem_wdata,
  input  logic [WIDTH-1:0]                 mem_rdata,
  input  logic                             mem_resp
);

  localparam int LB  = lane_bits(WIDTH);
  localparam int LW  = $clog2(MAX_LEVELS + 1);
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LW-1:0]  MAX_LV    = LW'(MAX_LEVELS);
  localparam logic [WCW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;

  mem_seq_state_t   state_q, state_d;
  mem_err_t         err_q, err_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             write_q, write_d;
  logic             byte_q, byte_d;
  logic [LW-1:0]    level_cnt_q, level_cnt_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;

  logic             in_op;
  logic             word_op;
  logic             misaligned;
  logic             active;
  logic             byte_wr;
  logic [WIDTH-1:0] lane_rdata;

  // A misaligned word operation never raises a strobe; it only reports.
  assign in_op      = (state_q == MS_IND) || (state_q == MS_ACCESS);
  assign word_op    = (state_q == MS_IND) || ((state_q == MS_ACCESS) && !byte_q);
  assign misaligned = word_op && (addr_q[LB-1:0] != '0);
  assign active     = in_op && !misaligned;
  assign byte_wr    = (state_q == MS_ACCESS) && write_q && byte_q;

  assign req_ready   = (state_q == MS_IDLE);
  assign done        = (state_q == MS_FINISH);
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign mem_address = addr_q;
  assign mem_read    = active && ((state_q == MS_IND) || !write_q);
  assign mem_write   = active && (state_q == MS_ACCESS) && write_q;

  mem_lane_sel #(
    .WIDTH (WIDTH)
  ) u_lane_sel (
    .lane       (addr_q[LB-1:0]),
    .byte_mode  (byte_q),
    .byte_wr    (byte_wr),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wdata_out  (mem_wdata),
    .byte_en    (mem_byte_enable),
    .rdata_byte (lane_rdata)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    write_d     = write_q;
    byte_d      = byte_q;
    level_cnt_d = level_cnt_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      MS_IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          write_d     = req_write;
          byte_d      = req_byte;
          err_d       = ERR_NONE;
          wait_cnt_d  = '0;
          level_cnt_d = (req_levels > MAX_LV) ? MAX_LV : req_levels;
          state_d     = (level_cnt_d != '0) ? MS_IND : MS_ACCESS;
        end
      end
      MS_IND, MS_ACCESS: begin
        if (misaligned) begin
          err_d   = ERR_ALIGN;
          state_d = MS_FINISH;
        end else if (mem_resp) begin
          // A response in the last allowed cycle beats the timeout.
          wait_cnt_d = '0;
          if (state_q == MS_IND) begin
            addr_d      = mem_rdata;
            level_cnt_d = level_cnt_q - LW'(1);
            if (level_cnt_q == LW'(1)) state_d = MS_ACCESS;
          end else begin
            if (!write_q) rdata_d = byte_q ? lane_rdata : mem_rdata;
            err_d   = ERR_NONE;
            state_d = MS_FINISH;
          end
        end else if ((TIMEOUT > 0) && (wait_cnt_q == WAIT_LAST)) begin
          err_d   = ERR_TIMEOUT;
          state_d = MS_FINISH;
        end else if (TIMEOUT > 0) begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      MS_FINISH: state_d = MS_IDLE;
      default:   state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MS_IDLE;
      err_q       <= ERR_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
      level_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      write_q     <= write_d;
      byte_q      <= byte_d;
      level_cnt_q <= level_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_access_seq : directed + random transactions against a memory model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_seq;

  localparam int TO    = 4;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_byte;
  logic [1:0]  req_levels;
  logic [15:0] req_addr, req_wdata;
  logic        done;
  logic [1:0]  err;
  logic [15:0] rdata, mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [1:0]  mem_byte_enable;

  always #5 clk = ~clk;

  mem_access_seq #(
    .WIDTH      (16),
    .MAX_LEVELS (3),
    .TIMEOUT    (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_byte        (req_byte),
    .req_levels      (req_levels),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .done            (done),
    .err             (err),
    .rdata           (rdata),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  logic [15:0] mem     [32768];
  logic [15:0] ref_mem [32768];
  logic [16:0] obs_q [$];
  int          lat_cfg = 0;
  int          strobe_cycles = 0;
  logic [15:0] last_wdata = '0;
  logic [1:0]  last_be = '0;
  logic [15:0] exp_rdata = '0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setw(input logic [15:0] a, input logic [15:0] v);
    mem[a[15:1]]     = v;
    ref_mem[a[15:1]] = v;
  endtask

  // Memory responder: answers each operation after lat_cfg wait cycles.
  initial begin
    int cnt;
    cnt = 0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_resp = 1'b0;
        cnt = 0;
      end else begin
        if (mem_resp) begin
          mem_resp = 1'b0;
          cnt = 0;
        end
        mem_rdata = 16'($urandom);
        if (mem_read || mem_write) begin
          strobe_cycles++;
          if (cnt == 0) obs_q.push_back({mem_write, mem_address});
          if (cnt == lat_cfg) begin
            mem_resp = 1'b1;
            if (mem_read) begin
              mem_rdata = mem[mem_address[15:1]];
            end else begin
              last_wdata = mem_wdata;
              last_be    = mem_byte_enable;
              if (mem_byte_enable[0]) mem[mem_address[15:1]][7:0]  = mem_wdata[7:0];
              if (mem_byte_enable[1]) mem[mem_address[15:1]][15:8] = mem_wdata[15:8];
            end
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Transaction-level model: walk the pointer chain, then predict and compare.
  task automatic run_txn(input logic wr, input logic byt, input logic [1:0] lv,
                         input logic [15:0] addr, input logic [15:0] wd, input int lat);
    logic [16:0] exp_q [$];
    logic [15:0] a;
    logic [1:0]  e_err;
    int          cyc, e_strobes, got, n;
    a = addr; e_err = 2'b00; cyc = 0; e_strobes = 0;
    for (int i = 0; i < int'(lv); i++) begin
      if (a[0]) begin e_err = 2'b01; cyc += 1; break; end
      exp_q.push_back({1'b0, a});
      if (lat >= TO) begin e_err = 2'b10; cyc += TO; e_strobes += TO; break; end
      cyc += lat + 1; e_strobes += lat + 1;
      a = ref_mem[a[15:1]];
    end
    if (e_err == 2'b00) begin
      if (!byt && a[0]) begin
        e_err = 2'b01; cyc += 1;
      end else begin
        exp_q.push_back({wr, a});
        if (lat >= TO) begin
          e_err = 2'b10; cyc += TO; e_strobes += TO;
        end else begin
          cyc += lat + 1; e_strobes += lat + 1;
          if (!wr) begin
            if (!byt)     exp_rdata = ref_mem[a[15:1]];
            else if (a[0]) exp_rdata = {8'h00, ref_mem[a[15:1]][15:8]};
            else           exp_rdata = {8'h00, ref_mem[a[15:1]][7:0]};
          end else if (!byt) ref_mem[a[15:1]] = wd;
          else if (a[0])     ref_mem[a[15:1]][15:8] = wd[7:0];
          else               ref_mem[a[15:1]][7:0]  = wd[7:0];
        end
      end
    end

    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_byte = byt; req_levels = lv;
    req_addr = addr; req_wdata = wd;
    lat_cfg = lat; obs_q.delete(); strobe_cycles = 0;
    @(posedge clk);
    got = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_write = 1'($urandom); req_byte = 1'($urandom);
        req_levels = 2'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      end
      if (done) begin got = k; break; end
    end
    chk("done_latency", 32'(got), 32'(cyc + 1));
    chk("err", 32'(err), 32'(e_err));
    chk("rdata", 32'(rdata), 32'(exp_rdata));
    chk("strobes_at_done", 32'({mem_read, mem_write}), 32'd0);
    chk("strobe_cycles", 32'(strobe_cycles), 32'(e_strobes));
    chk("op_count", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("op_addr", 32'(obs_q[i]), 32'(exp_q[i]));
    chk("mem_word", 32'(mem[a[15:1]]), 32'(ref_mem[a[15:1]]));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic seen_done;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_levels = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end

    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_read", 32'(mem_read), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_be", 32'(mem_byte_enable), 32'h3);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    setw(16'h0040, 16'hBEEF);
    run_txn(1'b0, 1'b0, 2'd0, 16'h0040, 16'h0000, 3);

    setw(16'h0010, 16'h0020);
    setw(16'h0020, 16'h0030);
    setw(16'h0030, 16'h1234);
    run_txn(1'b0, 1'b0, 2'd2, 16'h0010, 16'h0000, 0);

    run_txn(1'b1, 1'b1, 2'd0, 16'h0101, 16'h00A5, 1);
    chk("bst_odd_wdata", 32'(last_wdata), 32'hA5A5);
    chk("bst_odd_be", 32'(last_be), 32'h2);
    run_txn(1'b1, 1'b1, 2'd0, 16'h0100, 16'h003C, 0);
    chk("bst_even_wdata", 32'(last_wdata), 32'h3C3C);
    chk("bst_even_be", 32'(last_be), 32'h1);

    run_txn(1'b0, 1'b0, 2'd0, 16'h0003, 16'h0000, 0);
    run_txn(1'b0, 1'b0, 2'd0, 16'h0050, 16'h0000, NEVER);
    run_txn(1'b0, 1'b0, 2'd0, 16'h0050, 16'h0000, TO - 1);
    run_txn(1'b0, 1'b1, 3'd3 > 2 ? 2'd3 : 2'd0, 16'h0010, 16'h0000, 2);

    // Reset in the middle of an indirection wait.
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_levels = 2'd2;
    req_addr = 16'h0010; lat_cfg = NEVER;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("ind_read_before_rst", 32'(mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_read", 32'(mem_read), 32'd0);
    chk("arst_write", 32'(mem_write), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_be", 32'(mem_byte_enable), 32'h3);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("arst_no_done", 32'(seen_done), 32'd0);
    chk("arst_rdata", 32'(rdata), 32'd0);
    exp_rdata = '0;
    rst_n = 1'b1;
    run_txn(1'b0, 1'b0, 2'd2, 16'h0010, 16'h0000, 1);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] p, ad, nx;
      logic [1:0]  lv;
      int          lat;
      lv = 2'($urandom_range(0, 3));
      ad = 16'($urandom);
      if ($urandom_range(0, 7) != 0) ad[0] = 1'b0;
      p = ad;
      for (int j = 0; j < int'(lv); j++) begin
        nx = 16'($urandom);
        if ($urandom_range(0, 7) != 0) nx[0] = 1'b0;
        setw(p, nx);
        p = nx;
      end
      lat = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
      run_txn(1'($urandom), 1'($urandom), lv, ad, 16'($urandom), lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Parametrised memory-transaction sequencer used by the next-generation multicycle control unit.
- Replaces the hand-coded wait-for-`mem_resp` states (load, indirect load, byte load/store, trap-vector read) with one engine.
- The engine supports:
  - configurable data width;
  - chained indirection depth;
  - byte-lane access;
  - a bounded wait timeout.
- The control FSM issues one request and waits for `done`; this block alone drives the memory port.

Parameters:
- WIDTH, 16, data/address width in bits; multiple of 8, at least 16.
- MAX_LEVELS, 3, maximum indirection reads before the final access.
- TIMEOUT, 255, maximum cycles to wait for `mem_resp` per memory operation; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high when a request can be accepted (IDLE).
- req_write  in  1  1 = final access is a write, 0 = read.
- req_byte  in  1  1 = final access is byte-sized, 0 = word.
- req_levels  in  $clog2(MAX_LEVELS+1)  number of indirection reads; 0 = direct.
- req_addr  in  WIDTH  initial address.
- req_wdata  in  WIDTH  store data; for a byte store, bits [7:0] are used.
- done  out  1  one-cycle completion pulse.
- err  out  2  error code, valid with `done`: 00 ok, 01 misaligned, 10 timeout.
- rdata  out  WIDTH  load result, held from `done` until the next accepted request.
- mem_address  out  WIDTH  memory address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_byte_enable  out  WIDTH/8  lane mask.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data.
- mem_resp  in  1  memory completion.

Behaviour:
- **Reset:** async reset, active when `rst_n`=0. Effects:
  - state=IDLE;
  - `done`=0, `err`=00, `rdata`=0;
  - `mem_read`=0, `mem_write`=0, `mem_byte_enable`=all ones, `mem_address`=0, `mem_wdata`=0.
  - Reset mid-transaction aborts it immediately; no `done` is produced.
- **States:** IDLE, IND, ACCESS, FINISH.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch all `req_*` fields and set `level_cnt`=`req_levels` (values above MAX_LEVELS saturate to MAX_LEVELS).
  - Next state is IND if `level_cnt`>0, else ACCESS.
  - `req_ready`=0 in every other state; `req_valid` is ignored there.
- **IND:**
  - Drive `mem_read`=1, `mem_address`=`addr_q`, all lanes enabled.
  - On `mem_resp`: `addr_q` <= `mem_rdata` and `level_cnt` decrements. Go to ACCESS when `level_cnt` reaches 0, otherwise stay in IND for the next read.
  - `mem_read` stays high across back-to-back levels.
- **Alignment check:** done on entry to each word operation (IND read, or ACCESS with `req_byte`=0).
  - `addr_q` must have its low $clog2(WIDTH/8) bits equal to 0.
  - If not: no memory strobe is issued; go to FINISH with `err`=01.
- **ACCESS, read:**
  - `mem_read`=1.
  - On `mem_resp`, capture the load result into `rdata`:
    - word: `rdata` = `mem_rdata`;
    - byte: `rdata` = zero-extended lane selected by the low address bits.
- **ACCESS, write:**
  - `mem_write`=1.
  - word: `mem_wdata` = `wdata_q`, all lanes enabled.
  - byte: `mem_wdata` = `wdata_q[7:0]` replicated to every lane; `mem_byte_enable` = one-hot on lane `addr_q` low bits (WIDTH=16: even address -> 01, odd -> 10).
- **Strobes:** held constant from entry to the ACCESS/IND state until the `mem_resp` cycle inclusive; they drop in the cycle after `mem_resp`.
- **Timeout:**
  - A wait counter clears on entering each memory operation and increments on each cycle without `mem_resp`.
  - When it reaches TIMEOUT: strobes drop, go to FINISH with `err`=10.
  - If `mem_resp` arrives in the same cycle the counter reaches TIMEOUT, the response wins and the operation succeeds.
- **FINISH:** `done`=1 for exactly one cycle with the final `err`, then IDLE. `rdata` is unchanged on error.
- **Latency**, zero memory wait (`mem_resp` in first strobe cycle):
  - direct access: accept -> ACCESS 1 cycle -> FINISH; `done` is 2 cycles after acceptance;
  - each indirection level adds 1 cycle.
- **Combinational path:** none from `req_*` to `mem_*`; all memory outputs derive from registered state.

Decomposition:
- Shared package (lc3b_types) gains:
  - `mem_err_t` enum (ERR_NONE, ERR_ALIGN, ERR_TIMEOUT);
  - `mem_seq_state_t` enum;
  - a localparam function for lane count.
- One sub-module, mem_lane_sel:
  - combinational byte-lane select, zero-extend and write-replicate;
  - parametrised by WIDTH.
- FSM, counters and registers stay in mem_access_seq.

Test Plan:
- **Direct word load:** WIDTH=16, `req_addr`=0x0040, `mem_rdata`=0xBEEF, `mem_resp` after 3 wait cycles -> `mem_read` high for 4 cycles, `done` one cycle later, `rdata`=0xBEEF, `err`=00.
- **Double indirection load:** `req_levels`=2, mem[0x10]=0x20, mem[0x20]=0x30, mem[0x30]=0x1234 -> reads issued at 0x10, 0x20, 0x30 in order, `rdata`=0x1234.
- **Byte store, odd address:** `req_addr`=0x0101, `req_wdata`=0x00A5 -> `mem_wdata`=0xA5A5, `mem_byte_enable`=10; even address 0x0100 -> 01.
- **Misaligned word load:** `req_addr`=0x0003 -> no `mem_read`, `done` with `err`=01 two cycles after acceptance, `rdata` unchanged.
- **Timeout and race:** TIMEOUT=4, `mem_resp` never asserted -> strobe drops after 4 cycles, `err`=10; repeat with `mem_resp` on cycle 4 -> `err`=00.
- **Async reset:** `rst_n` low during IND wait -> all strobes 0 immediately, no `done`; next request executes normally.
